half_adder_unit: RTL and testbench

Vectorised half-adder: each of WIDTH bit lanes adds `a[i]` and `b[i]` with no carry-in. Each lane gives a sum bit and a carry-out bit. Results are available combinationally and as a one-cycle registered copy. An optional saturating counter records how many cycles had at least one carry. The block is an arithmetic leaf cell for wider adder trees and for bring-up debug.

---
 rtl/half_adder_unit_pkg.sv | 10 +
 rtl/half_adder_cell.sv | 14 +
 rtl/half_adder_unit.sv | 91 +++++++++
 tb/tb_half_adder_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/half_adder_unit_pkg.sv
// Shared defaults and types for the vectorised half-adder unit.
package half_adder_unit_pkg;

   localparam int unsigned HA_WIDTH_DEF = 1;
   localparam int unsigned HA_CNT_W_DEF = 16;

   // Counter word at the default counter width.
   typedef logic [HA_CNT_W_DEF-1:0] ha_cnt_t;

endpackage

// File: rtl/half_adder_cell.sv
// Single-lane combinational half adder: sum = a ^ b, co = a & b.
module half_adder_cell
   import half_adder_unit_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic sum,
   output logic co
);

   assign sum = a ^ b;
   assign co  = a & b;

endmodule

// File: rtl/half_adder_unit.sv
// Vectorised half adder with a combinational result, a one-cycle registered
// copy and an optional saturating carry-event counter.
// Optional feature macro: HALF_ADDER_UNIT_STATS_EN builds the counter; when it
// is undefined carry_cnt is tied to zero.
module half_adder_unit
   import half_adder_unit_pkg::*;
#(
   parameter int unsigned WIDTH = HA_WIDTH_DEF,
   parameter int unsigned CNT_W = HA_CNT_W_DEF
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] co,
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] co_q,
   output logic [CNT_W-1:0] carry_cnt
);

   // Independent lanes keep X/Z confined to the lane it arrives on.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_cell u_cell (
         .a   (a[i]),
         .b   (b[i]),
         .sum (sum[i]),
         .co  (co[i])
      );
   end

   logic [WIDTH-1:0] sum_d;
   logic [WIDTH-1:0] co_d;

   // Next state of the registered copy: clear beats capture, otherwise hold.
   always_comb begin
      sum_d = sum_q;
      co_d  = co_q;
      if (clr) begin
         sum_d = '0;
         co_d  = '0;
      end else if (en) begin
         sum_d = sum;
         co_d  = co;
      end
   end

   // Registered copy of the lane results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q <= '0;
         co_q  <= '0;
      end else begin
         sum_q <= sum_d;
         co_q  <= co_d;
      end
   end

`ifdef HALF_ADDER_UNIT_STATS_EN
   localparam logic [CNT_W-1:0] CntMax = '1;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count captured cycles with any lane carrying; stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (|co) && (cnt_q != CntMax)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Carry-event counter state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign carry_cnt = cnt_q;
`else
   assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_half_adder_unit.sv
// Self-checking bench for half_adder_unit: three instances (1-lane default,
// 4-lane, 1-lane with a 2-bit counter) share clock and reset.
module tb_half_adder_unit;
   import half_adder_unit_pkg::*;

`ifdef HALF_ADDER_UNIT_STATS_EN
   localparam bit Stats = 1'b1;
`else
   localparam bit Stats = 1'b0;
`endif

   typedef struct {
      string      name;
      logic [3:0] s;
      logic [3:0] c;
      ha_cnt_t    n;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // 1-lane default instance
   logic        a1, b1, sum1, co1, en1, clr1, sumq1, coq1;
   logic [15:0] cnt1;
   // 4-lane instance
   logic [3:0]  a4, b4, sum4, co4, sumq4, coq4;
   logic        en4, clr4;
   logic [15:0] cnt4;
   // 1-lane instance with a 2-bit counter
   logic        ac, bc, sumc, coc, enc, clrc, sumqc, coqc;
   logic [1:0]  cntc;

   half_adder_unit #(.WIDTH(1), .CNT_W(16)) u_dut1 (
      .a(a1), .b(b1), .sum(sum1), .co(co1), .clk(clk), .rst_n(rst_n), .en(en1),
      .clr(clr1), .sum_q(sumq1), .co_q(coq1), .carry_cnt(cnt1)
   );
   half_adder_unit #(.WIDTH(4), .CNT_W(16)) u_dut4 (
      .a(a4), .b(b4), .sum(sum4), .co(co4), .clk(clk), .rst_n(rst_n), .en(en4),
      .clr(clr4), .sum_q(sumq4), .co_q(coq4), .carry_cnt(cnt4)
   );
   half_adder_unit #(.WIDTH(1), .CNT_W(2)) u_dutc (
      .a(ac), .b(bc), .sum(sumc), .co(coc), .clk(clk), .rst_n(rst_n), .en(enc),
      .clr(clrc), .sum_q(sumqc), .co_q(coqc), .carry_cnt(cntc)
   );

   // Bench-side state of the 4-lane instance's registered outputs.
   logic [3:0] m4_s, m4_c;
   ha_cnt_t    m4_n;

   task automatic test_comb();
      logic [3:0] sum_tbl;
      logic [3:0] co_tbl;
      exp_t       e;
      sum_tbl = 4'b0110;
      co_tbl  = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         a1 = (i >= 2);
         b1 = (i == 1) || (i == 3);
         e.name = $sformatf("comb_ab%0d", i);
         e.s = {3'b000, sum_tbl[i]};
         e.c = {3'b000, co_tbl[i]};
         e.n = '0;
         sb.push_back(e);
         #1;
         e = sb.pop_front();
         n_vec++;
         if (sum1 !== e.s[0] || co1 !== e.c[0]) begin
            n_bad++;
            $display("FAIL %s: got sum=%b co=%b, want sum=%b co=%b",
                     e.name, sum1, co1, e.s[0], e.c[0]);
         end
         #4;
      end
   endtask

   task automatic test_reset();
      exp_t e;
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         a1 = i[0]; b1 = i[1]; en1 = 1'b1;
         a4 = 4'(i * 5); b4 = 4'hF; en4 = 1'b1;
         ac = 1'b1; bc = 1'b1; enc = 1'b1;
         @(posedge clk); #1;
         n_vec++;
         if (sumq1 !== 1'b0 || coq1 !== 1'b0 || cnt1 !== 16'd0 || sumq4 !== 4'd0 ||
             coq4 !== 4'd0 || cnt4 !== 16'd0 || coqc !== 1'b0 || cntc !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_hold%0d: got q1=%b%b c1=%0d q4=%h%h c4=%0d qc=%b cc=%0d, want all 0",
                     i, sumq1, coq1, cnt1, sumq4, coq4, cnt4, coqc, cntc);
         end
      end
      @(negedge clk);
      en1 = 1'b0; en4 = 1'b0; enc = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      a1 = 1'b1; b1 = 1'b1; en1 = 1'b1;
      e.name = "first_capture";
      e.s = 4'd0; e.c = 4'd1; e.n = Stats ? ha_cnt_t'(1) : '0;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (sumq1 !== e.s[0] || coq1 !== e.c[0] || cnt1 !== e.n) begin
         n_bad++;
         $display("FAIL %s: got sum_q=%b co_q=%b cnt=%0d, want %b %b %0d",
                  e.name, sumq1, coq1, cnt1, e.s[0], e.c[0], e.n);
      end
      @(negedge clk);
      en1 = 1'b0;
      m4_s = '0; m4_c = '0; m4_n = '0;
   endtask

   task automatic test_vector4();
      logic [3:0] ta[3], tb_[3], ts[3], tc[3];
      exp_t       e;
      ta = '{4'b1100, 4'b0110, 4'b0000};
      tb_ = '{4'b1010, 4'b0011, 4'b1111};
      ts = '{4'b0110, 4'b0101, 4'b1111};
      tc = '{4'b1000, 4'b0010, 4'b0000};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a4 = ta[i]; b4 = tb_[i]; en4 = 1'b1;
         #1;
         n_vec++;
         if (sum4 !== ts[i] || co4 !== tc[i]) begin
            n_bad++;
            $display("FAIL vec4_comb%0d: got sum=%b co=%b, want %b %b", i, sum4, co4, ts[i], tc[i]);
         end
         m4_s = ts[i]; m4_c = tc[i];
         if (Stats && tc[i] != 4'd0) m4_n = m4_n + 1'b1;
         e.name = $sformatf("vec4_reg%0d", i);
         e.s = m4_s; e.c = m4_c; e.n = m4_n;
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (sumq4 !== e.s || coq4 !== e.c || cnt4 !== e.n) begin
            n_bad++;
            $display("FAIL %s: got sum_q=%b co_q=%b cnt=%0d, want %b %b %0d",
                     e.name, sumq4, coq4, cnt4, e.s, e.c, e.n);
         end
      end
   endtask

   task automatic test_hold_clear();
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         en4 = 1'b0;
         a4 = 4'($urandom_range(0, 15)) | 4'b1000;
         b4 = 4'b1111;
         e.name = $sformatf("hold%0d", i);
         e.s = m4_s; e.c = m4_c; e.n = m4_n;
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (sumq4 !== e.s || coq4 !== e.c || cnt4 !== e.n) begin
            n_bad++;
            $display("FAIL %s: got sum_q=%b co_q=%b cnt=%0d, want %b %b %0d",
                     e.name, sumq4, coq4, cnt4, e.s, e.c, e.n);
         end
      end
      @(negedge clk);
      a4 = 4'hF; b4 = 4'hF; en4 = 1'b1; clr4 = 1'b1;
      m4_s = '0; m4_c = '0; m4_n = '0;
      e.name = "clr_over_en";
      e.s = m4_s; e.c = m4_c; e.n = m4_n;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (sumq4 !== e.s || coq4 !== e.c || cnt4 !== e.n) begin
         n_bad++;
         $display("FAIL %s: got sum_q=%b co_q=%b cnt=%0d, want %b %b %0d",
                  e.name, sumq4, coq4, cnt4, e.s, e.c, e.n);
      end
      @(negedge clk);
      clr4 = 1'b0; en4 = 1'b0;
   endtask

   task automatic test_saturate();
      ha_cnt_t sat_tbl[5];
      exp_t    e;
      sat_tbl = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd3};
      @(negedge clk);
      clrc = 1'b1; enc = 1'b0;
      @(negedge clk);
      clrc = 1'b0; ac = 1'b1; bc = 1'b1; enc = 1'b1;
      for (int i = 0; i < 5; i++) begin
         e.name = $sformatf("sat%0d", i);
         e.s = 4'd0; e.c = 4'd1; e.n = Stats ? sat_tbl[i] : '0;
         sb.push_back(e);
         @(posedge clk); #1;
         e = sb.pop_front();
         n_vec++;
         if (sumqc !== e.s[0] || coqc !== e.c[0] || cntc !== e.n[1:0]) begin
            n_bad++;
            $display("FAIL %s: got sum_q=%b co_q=%b cnt=%0d, want %b %b %0d",
                     e.name, sumqc, coqc, cntc, e.s[0], e.c[0], e.n[1:0]);
         end
      end
      @(negedge clk);
      enc = 1'b0;
   endtask

   task automatic test_async_reset();
      exp_t e;
      @(negedge clk);
      clrc = 1'b1;
      @(negedge clk);
      clrc = 1'b0; enc = 1'b1; ac = 1'b1; bc = 1'b1;
      @(posedge clk);
      @(posedge clk); #1;
      n_vec++;
      if (cntc !== (Stats ? 2'd2 : 2'd0)) begin
         n_bad++;
         $display("FAIL pre_reset_cnt: got %0d, want %0d", cntc, Stats ? 2 : 0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (cntc !== 2'd0 || coqc !== 1'b0 || coq1 !== 1'b0 || cnt1 !== 16'd0) begin
         n_bad++;
         $display("FAIL async_reset: got cnt=%0d co_q=%b co_q1=%b cnt1=%0d, want all 0",
                  cntc, coqc, coq1, cnt1);
      end
      @(negedge clk);
      enc = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (cntc !== 2'd0 || coqc !== 1'b0) begin
         n_bad++;
         $display("FAIL post_release_hold: got cnt=%0d co_q=%b, want 0 0", cntc, coqc);
      end
      @(negedge clk);
      enc = 1'b1;
      e.name = "post_release_capture";
      e.s = 4'd0; e.c = 4'd1; e.n = Stats ? ha_cnt_t'(1) : '0;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_vec++;
      if (sumqc !== e.s[0] || coqc !== e.c[0] || cntc !== e.n[1:0]) begin
         n_bad++;
         $display("FAIL %s: got sum_q=%b co_q=%b cnt=%0d, want %b %b %0d",
                  e.name, sumqc, coqc, cntc, e.s[0], e.c[0], e.n[1:0]);
      end
      @(negedge clk);
      enc = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      a1 = 1'b0; b1 = 1'b0; en1 = 1'b0; clr1 = 1'b0;
      a4 = '0; b4 = '0; en4 = 1'b0; clr4 = 1'b0;
      ac = 1'b0; bc = 1'b0; enc = 1'b0; clrc = 1'b0;
      m4_s = '0; m4_c = '0; m4_n = '0;
      test_comb();
      test_reset();
      test_vector4();
      test_hold_clear();
      test_saturate();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
